// File: rtl/random_gen.sv
// random_gen: parametrised Galois-LFSR word source with valid/ready output,
// enable, runtime reseed and optional per-word decimation (STEPS shifts/word).
// Optional feature macro: RAND_GEN_CNT_EN adds the word_cnt accepted-word counter.
module random_gen #(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = 8'h70,
    parameter logic [WIDTH-1:0]  SEED  = 8'hFF,
    parameter int                STEPS = 1,
    parameter int                CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             rand_ready,
    output logic             rand_valid,
    output logic [WIDTH-1:0] rand_num
`ifdef RAND_GEN_CNT_EN
    ,
    output logic [CNT_W-1:0] word_cnt
`endif
);

    // Step counter only has to reach STEPS-1; keep at least one bit so the
    // STEPS==1 build still elaborates cleanly.
    localparam int SC_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SC_W-1:0] STEP_ONE  = SC_W'(1);
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEPS - 1);

    // Reject configurations that cannot produce a usable sequence.
    if (WIDTH < 2 || STEPS < 1 || CNT_W < 1 || SEED == '0) begin : g_bad_param
        $error("random_gen: illegal parameter set");
    end

    typedef enum logic {
        ST_VALID = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [SC_W-1:0]   step_cnt_q, step_cnt_d;
    logic              accept;

    // One Galois shift: the outgoing MSB feeds bit 0 and is XORed into every
    // tapped position. TAPS[0] is deliberately ignored.
    function automatic logic [WIDTH-1:0] lfsr_nxt(input logic [WIDTH-1:0] s);
        logic             m;
        logic [WIDTH-1:0] r;
        m = s[WIDTH-1];
        r = {s[WIDTH-2:0], m};
        for (int i = 1; i < WIDTH; i++) begin
            r[i] = r[i] ^ (TAPS[i] & m);
        end
        return r;
    endfunction

    // A fresh word is offered only when idle in ST_VALID; a reseed cycle
    // suppresses valid so a concurrent ready cannot consume the stale word.
    assign rand_valid = en & (state_q == ST_VALID) & ~seed_load;
    assign accept     = rand_valid & rand_ready;
    assign rand_num   = lfsr_q;

    // Next-state logic: reseed first, then handshake, then decimation shifts.
    always_comb begin
        lfsr_d     = lfsr_q;
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        if (seed_load) begin
            // A zero seed would lock the LFSR, so fall back to SEED.
            lfsr_d     = (seed_in == '0) ? SEED : seed_in;
            state_d    = ST_VALID;
            step_cnt_d = '0;
        end else if (state_q == ST_VALID) begin
            if (accept) begin
                lfsr_d = lfsr_nxt(lfsr_q);
                if (STEPS > 1) begin
                    step_cnt_d = STEP_ONE;
                    state_d    = ST_SHIFT;
                end
            end
        end else if (en) begin
            lfsr_d = lfsr_nxt(lfsr_q);
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_d = '0;
                state_d    = ST_VALID;
            end else begin
                step_cnt_d = step_cnt_q + STEP_ONE;
            end
        end
    end

    // State registers; reset aborts any decimation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q     <= SEED;
            state_q    <= ST_VALID;
            step_cnt_q <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
        end
    end

`ifdef RAND_GEN_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accepted-word counter; wraps naturally, cleared on reseed.
    always_comb begin
        cnt_d = cnt_q;
        if (seed_load) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_random_gen.sv
// tb_random_gen: scoreboard bench for random_gen. Two instances (STEPS=1 and
// STEPS=4) share one randomized stimulus stream; a word-level reference model
// predicts valid/word per cycle and a negedge monitor compares.
module tb_random_gen;

    localparam int          CNT_W = 4;
    localparam logic [7:0]  TAPS  = 8'h70;
    localparam logic [7:0]  SEED  = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic       rand_ready = 1'b0;

    logic       valid1, valid4;
    logic [7:0] num1, num4;
`ifdef RAND_GEN_CNT_EN
    logic [CNT_W-1:0] cnt1, cnt4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    random_gen #(.WIDTH(8), .TAPS(TAPS), .SEED(SEED), .STEPS(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .rand_ready(rand_ready), .rand_valid(valid1), .rand_num(num1)
`ifdef RAND_GEN_CNT_EN
        , .word_cnt(cnt1)
`endif
    );

    random_gen #(.WIDTH(8), .TAPS(TAPS), .SEED(SEED), .STEPS(4), .CNT_W(CNT_W)) dut4 (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .rand_ready(rand_ready), .rand_valid(valid4), .rand_num(num4)
`ifdef RAND_GEN_CNT_EN
        , .word_cnt(cnt4)
`endif
    );

    typedef struct {
        logic       v1;
        logic [7:0] n1;
        int         c1;
        logic       v4;
        logic [7:0] n4;
        int         c4;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: index 0 = STEPS 1, index 1 = STEPS 4.
    // pend = shifts still owed before the next word may be offered.
    int m_lfsr[2];
    int m_pend[2];
    int m_cnt[2];
    int m_steps[2] = '{1, 4};

    function automatic int galois_next(input int s);
        int v;
        v = (s << 1) & 255;
        if (s >= 128) v = v ^ ((TAPS & 8'hFE) | 1);
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lfsr[k] = SEED;
            m_pend[k] = 0;
            m_cnt[k]  = 0;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, push the predicted outputs, advance model.
    task automatic cycle(input logic e, input logic ld, input logic [7:0] sd, input logic rdy);
        exp_t x;
        logic v[2];
        @(posedge clk);
        #1;
        en = e; seed_load = ld; seed_in = sd; rand_ready = rdy;
        for (int k = 0; k < 2; k++) v[k] = e && (m_pend[k] == 0) && !ld;
        x.v1 = v[0]; x.n1 = m_lfsr[0][7:0]; x.c1 = m_cnt[0];
        x.v4 = v[1]; x.n4 = m_lfsr[1][7:0]; x.c4 = m_cnt[1];
        exp_q.push_back(x);
        for (int k = 0; k < 2; k++) begin
            if (ld) begin
                m_lfsr[k] = (sd == 8'h00) ? int'(SEED) : int'(sd);
                m_pend[k] = 0;
                m_cnt[k]  = 0;
            end else if (v[k] && rdy) begin
                m_lfsr[k] = galois_next(m_lfsr[k]);
                m_pend[k] = m_steps[k] - 1;
                m_cnt[k]  = (m_cnt[k] + 1) % (1 << CNT_W);
            end else if (m_pend[k] > 0 && e) begin
                m_lfsr[k] = galois_next(m_lfsr[k]);
                m_pend[k] = m_pend[k] - 1;
            end
        end
    endtask

    // Asynchronous reset away from the clock edge; outputs must snap at once.
    task automatic apply_reset(input logic en_v);
        @(negedge clk);
        #1;
        en = en_v; seed_load = 1'b0; rand_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_num1", num1, SEED);
        chk("rst_valid1", valid1, en_v);
        chk("rst_num4", num4, SEED);
        chk("rst_valid4", valid4, en_v);
`ifdef RAND_GEN_CNT_EN
        chk("rst_cnt1", cnt1, 0);
        chk("rst_cnt4", cnt4, 0);
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("valid_s1", valid1, x.v1);
            chk("num_s1", num1, x.n1);
            chk("valid_s4", valid4, x.v4);
            chk("num_s4", num4, x.n4);
`ifdef RAND_GEN_CNT_EN
            chk("cnt_s1", cnt1, x.c1);
            chk("cnt_s4", cnt4, x.c4);
`endif
        end
    end

    initial begin
        model_reset();
        apply_reset(1'b1);

        // Back-to-back words from reset (FF, 8F, 6F on the STEPS=1 instance).
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Stall with ready low, then release.
        apply_reset(1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Zero seed falls back to SEED; seed 01 then accept gives 02.
        cycle(1'b1, 1'b1, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Freeze decimation with en low, then resume.
        apply_reset(1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Reseed while en is low, and reseed in the middle of decimation.
        cycle(1'b0, 1'b1, 8'h5A, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Reset in the middle of decimation.
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        apply_reset(1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Randomized traffic with occasional resets and reseeds.
        for (int i = 0; i < 3000; i++) begin
            logic       e, ld, rdy;
            logic [7:0] sd;
            e   = ($urandom_range(0, 9) != 0);
            ld  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            sd  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 299) == 0) apply_reset(1'($urandom_range(0, 1)));
            cycle(e, ld, sd, rdy);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
